// File: rtl/id_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// id_regfile_scoreboard
//
// Instruction-decode side register file with a pending-write scoreboard.
// It consumes the MEM/WB write-back bundle, serves two combinational read
// ports to ID and keeps one saturating counter per register. Each counter
// tracks how many register-writing instructions are still in flight to that
// register, so the hazard logic can stall on busy operands.
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   defined   : a write-back in progress is visible on the read ports in the
//               same cycle, and busy is dropped for a register whose last
//               outstanding write is completing right now.
//   undefined : reads return the stored value only.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high; clears registers,
//                       counters and err_sticky
//   RegWrite            write-back enable
//   RegWriteDst         write-back destination index
//   MEM_WB_Forward_Data write-back data
//   rd_addr_a/b         read port indices (rs / rt)
//   rd_data_a/b         read port data (combinational)
//   busy_a/b            register at rd_addr_a/b has outstanding writes
//   issue_valid/dst     register-writing instruction leaves ID
//   kill_valid/dst      previously issued instruction is squashed
//   err_sticky          scoreboard overflow/underflow seen since reset
// ---------------------------------------------------------------------------
module id_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] RegWriteDst,
    input  logic [DATA_W-1:0] MEM_WB_Forward_Data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              kill_valid,
    input  logic [ADDR_W-1:0] kill_dst,
    output logic              err_sticky
);

    localparam int NREG  = 2**ADDR_W;
    localparam int SUM_W = CNT_W + 2;     // room for cnt+1 and cnt-2 signed
    localparam int CMAX  = 2**CNT_W - 1;

    logic [DATA_W-1:0]       regs     [NREG];
    logic [CNT_W-1:0]        cnt      [NREG];
    logic [CNT_W-1:0]        cnt_next [NREG];
    logic signed [SUM_W-1:0] cnt_raw  [NREG];
    logic                    cnt_err;

    // Unclamped signed count after applying one issue and up to two decrements.
    function automatic logic signed [SUM_W-1:0] cnt_sum(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             dec_wb,
        input logic             dec_kill
    );
        logic signed [SUM_W-1:0] s;
        s = signed'({2'b00, c});
        s = s + signed'(SUM_W'(inc));
        s = s - signed'(SUM_W'(dec_wb)) - signed'(SUM_W'(dec_kill));
        return s;
    endfunction

    function automatic logic cnt_oor(input logic signed [SUM_W-1:0] s);
        return (s < 0) || (s > signed'(SUM_W'(CMAX)));
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat(input logic signed [SUM_W-1:0] s);
        if (s < 0)
            return '0;
        else if (s > signed'(SUM_W'(CMAX)))
            return CNT_W'(CMAX);
        else
            return s[CNT_W-1:0];
    endfunction

    // Index 0 is never counted: its counter is pinned at zero.
    always_comb begin
        cnt_err     = 1'b0;
        cnt_raw[0]  = '0;
        cnt_next[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_raw[i]  = cnt_sum(cnt[i],
                                  issue_valid && (issue_dst == ADDR_W'(i)),
                                  RegWrite    && (RegWriteDst == ADDR_W'(i)),
                                  kill_valid  && (kill_dst == ADDR_W'(i)));
            cnt_next[i] = cnt_sat(cnt_raw[i]);
            if (cnt_oor(cnt_raw[i]))
                cnt_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                cnt[i] <= '0;
            err_sticky <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                cnt[i] <= cnt_next[i];
            if (cnt_err)
                err_sticky <= 1'b1;
        end
    end

    // Register file; index 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (RegWrite && (RegWriteDst != '0)) begin
            regs[RegWriteDst] <= MEM_WB_Forward_Data;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic wb_hit_a;
    logic wb_hit_b;

    assign wb_hit_a = RegWrite && (RegWriteDst != '0) && (RegWriteDst == rd_addr_a);
    assign wb_hit_b = RegWrite && (RegWriteDst != '0) && (RegWriteDst == rd_addr_b);

    assign rd_data_a = (rd_addr_a == '0) ? '0 :
                       wb_hit_a ? MEM_WB_Forward_Data : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 :
                       wb_hit_b ? MEM_WB_Forward_Data : regs[rd_addr_b];

    // The last outstanding write completing now no longer needs a stall.
    assign busy_a = (rd_addr_a != '0) && (cnt[rd_addr_a] != '0) &&
                    !(wb_hit_a && (cnt[rd_addr_a] == CNT_W'(1)));
    assign busy_b = (rd_addr_b != '0) && (cnt[rd_addr_b] != '0) &&
                    !(wb_hit_b && (cnt[rd_addr_b] == CNT_W'(1)));
`else
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

    // Pre-edge count: a write-back this cycle is covered by forwarding.
    assign busy_a = (rd_addr_a != '0) && (cnt[rd_addr_a] != '0);
    assign busy_b = (rd_addr_b != '0) && (cnt[rd_addr_b] != '0);
`endif

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_regfile_scoreboard
//
// Scoreboard bench for id_regfile_scoreboard. A driver applies one stimulus
// vector per cycle, computes the expected read-port view from a behavioural
// model (plain arrays of values and integer pending counts) and queues it.
// A monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_id_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int NREG   = 32;
    localparam int CMAX   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              RegWrite = 1'b0;
    logic [ADDR_W-1:0] RegWriteDst = '0;
    logic [DATA_W-1:0] MEM_WB_Forward_Data = '0;
    logic [ADDR_W-1:0] rd_addr_a = '0;
    logic [ADDR_W-1:0] rd_addr_b = '0;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    logic              issue_valid = 1'b0;
    logic [ADDR_W-1:0] issue_dst = '0;
    logic              kill_valid = 1'b0;
    logic [ADDR_W-1:0] kill_dst = '0;
    logic              err_sticky;

    id_regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .RegWrite            (RegWrite),
        .RegWriteDst         (RegWriteDst),
        .MEM_WB_Forward_Data (MEM_WB_Forward_Data),
        .rd_addr_a           (rd_addr_a),
        .rd_addr_b           (rd_addr_b),
        .rd_data_a           (rd_data_a),
        .rd_data_b           (rd_data_b),
        .busy_a              (busy_a),
        .busy_b              (busy_b),
        .issue_valid         (issue_valid),
        .issue_dst           (issue_dst),
        .kill_valid          (kill_valid),
        .kill_dst            (kill_dst),
        .err_sticky          (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          we;
        int          wdst;
        logic [31:0] wdata;
        int          ra;
        int          rb;
        bit          iv;
        int          idst;
        bit          kv;
        int          kdst;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [31:0] da;
        logic [31:0] db;
        bit          ba;
        bit          bb;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Behavioural model: architectural values and outstanding-write counts.
    logic [31:0] m_reg [NREG];
    int          m_cnt [NREG];
    bit          m_err;

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(stim_t s, int addr);
        if (addr == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (s.we && s.wdst == addr) return s.wdata;
`endif
        return m_reg[addr];
    endfunction

    function automatic bit model_busy(stim_t s, int addr);
        if (addr == 0 || m_cnt[addr] == 0) return 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (s.we && s.wdst == addr && m_cnt[addr] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic void model_edge(stim_t s);
        for (int i = 1; i < NREG; i++) begin
            int n;
            n = m_cnt[i];
            if (s.iv && s.idst == i) n++;
            if (s.we && s.wdst == i) n--;
            if (s.kv && s.kdst == i) n--;
            if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
            if (n < 0)    begin n = 0;    m_err = 1'b1; end
            m_cnt[i] = n;
        end
        if (s.we && s.wdst != 0) m_reg[s.wdst] = s.wdata;
    endfunction

    function automatic stim_t idle(int ra, int rb);
        stim_t s;
        s = '{rst: 1'b0, we: 1'b0, wdst: 0, wdata: '0, ra: ra, rb: rb,
              iv: 1'b0, idst: 0, kv: 1'b0, kdst: 0};
        return s;
    endfunction

    // Drive one vector just after a rising edge, queue the expected view,
    // then advance the model across the next rising edge.
    task automatic step(input stim_t s);
        exp_t e;
        reset               = s.rst;
        RegWrite            = s.we;
        RegWriteDst         = ADDR_W'(s.wdst);
        MEM_WB_Forward_Data = s.wdata;
        rd_addr_a           = ADDR_W'(s.ra);
        rd_addr_b           = ADDR_W'(s.rb);
        issue_valid         = s.iv;
        issue_dst           = ADDR_W'(s.idst);
        kill_valid          = s.kv;
        kill_dst            = ADDR_W'(s.kdst);
        if (s.rst) model_clear();
        e.cyc = cyc;
        e.da  = model_read(s, s.ra);
        e.db  = model_read(s, s.rb);
        e.ba  = model_busy(s, s.ra);
        e.bb  = model_busy(s, s.rb);
        e.err = m_err;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (s.rst) model_clear();
        else       model_edge(s);
        cyc++;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, exp);
        end
    endtask

    // Monitor: the DUT's view is stable mid-cycle, so check on falling edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data_a", e.cyc, rd_data_a, e.da);
                chk("rd_data_b", e.cyc, rd_data_b, e.db);
                chk("busy_a", e.cyc, 32'(busy_a), 32'(e.ba));
                chk("busy_b", e.cyc, 32'(busy_b), 32'(e.bb));
                chk("err_sticky", e.cyc, 32'(err_sticky), 32'(e.err));
            end
        end
    end

    initial begin
        stim_t s;
        model_clear();
        @(posedge clk);
        #1;

        // Reset, read 5 and 0
        s = idle(5, 0); s.rst = 1'b1; step(s); step(s);
        step(idle(5, 0));

        // Write to index 0 discarded; write 7 visible next cycle
        s = idle(0, 7); s.we = 1; s.wdst = 0; s.wdata = 32'hDEADBEEF; step(s);
        step(idle(0, 7));
        s = idle(7, 0); s.we = 1; s.wdst = 7; s.wdata = 32'h12345678; step(s);
        step(idle(7, 0));

        // Same-cycle write/read of index 3
        s = idle(3, 3); s.we = 1; s.wdst = 3; s.wdata = 32'h11111111; step(s);
        step(idle(3, 3));
        s = idle(3, 7); s.we = 1; s.wdst = 3; s.wdata = 32'hA5A5A5A5; step(s);
        step(idle(3, 7));

        // Two issues to 9, then two write-backs
        s = idle(9, 9); s.iv = 1; s.idst = 9; step(s); step(s);
        step(idle(9, 0));
        s = idle(9, 9); s.we = 1; s.wdst = 9; s.wdata = 32'h99990001; step(s);
        step(idle(9, 9));
        s = idle(9, 9); s.we = 1; s.wdst = 9; s.wdata = 32'h99990002; step(s);
        step(idle(9, 9));

        // Issue + WB + kill on index 4 holding two outstanding writes
        s = idle(4, 0); s.iv = 1; s.idst = 4; step(s); step(s);
        s = idle(4, 4); s.iv = 1; s.idst = 4; s.we = 1; s.wdst = 4;
        s.wdata = 32'h44444444; s.kv = 1; s.kdst = 4; step(s);
        step(idle(4, 4));

        // Overflow on 2, underflow on 6, then reset mid-sequence
        s = idle(2, 6); s.iv = 1; s.idst = 2;
        for (int i = 0; i < 4; i++) step(s);
        step(idle(2, 6));
        s = idle(6, 2); s.kv = 1; s.kdst = 6; step(s);
        step(idle(6, 2));
        s = idle(2, 4); s.iv = 1; s.idst = 2; s.rst = 1'b1; step(s);
        step(idle(2, 4));

        // Randomised traffic concentrated on a few indices to force collisions
        for (int n = 0; n < 1500; n++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.we    = $urandom_range(0, 2) != 0;
            s.wdst  = $urandom_range(0, 7);
            s.wdata = $urandom;
            s.ra    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            s.rb    = $urandom_range(0, 7);
            s.iv    = $urandom_range(0, 1);
            s.idst  = $urandom_range(0, 7);
            s.kv    = ($urandom_range(0, 4) == 0);
            s.kdst  = $urandom_range(0, 7);
            step(s);
        end
        step(idle(0, 0));

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_regfile_scoreboard.md
Name: id_regfile_scoreboard

Overview:
- Instruction-decode-side consumer of the MEM/WB write-back bundle (RegWrite, RegWriteDst, write-back data).
- Holds the architectural register file and serves two combinational read ports to ID.
- Keeps a per-register pending-write scoreboard. Entries are incremented at issue and decremented at write-back or squash, so the hazard logic can stall on registers with outstanding writes.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; NREG = 2**ADDR_W entries.
- CNT_W, 2, width of each pending-write counter; max outstanding writes per register = 2**CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears the register file, all counters and err_sticky.
- RegWrite  input  1  write-back enable from MEM/WB.
- RegWriteDst  input  ADDR_W  write-back destination index.
- MEM_WB_Forward_Data  input  DATA_W  write-back data.
- rd_addr_a  input  ADDR_W  read port A index (rs).
- rd_addr_b  input  ADDR_W  read port B index (rt).
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational).
- busy_a  output  1  counter[rd_addr_a] != 0 and rd_addr_a != 0.
- busy_b  output  1  counter[rd_addr_b] != 0 and rd_addr_b != 0.
- issue_valid  input  1  a register-writing instruction leaves ID this cycle.
- issue_dst  input  ADDR_W  its destination index.
- kill_valid  input  1  a previously issued register-writing instruction is squashed (flush).
- kill_dst  input  ADDR_W  destination of the squashed instruction.
- err_sticky  output  1  scoreboard overflow/underflow seen since reset.

Behaviour:
Reset:
- All registers = 0, all counters = 0, err_sticky = 0.
- Therefore rd_data_a/b = 0 and busy_a/b = 0 while reset is asserted.

Write:
- On a clk edge with RegWrite=1 and RegWriteDst!=0: reg[RegWriteDst] <= MEM_WB_Forward_Data.
- Writes to index 0 are discarded; reg[0] always reads 0.

Read:
- Combinational: rd_data_x = (addr==0) ? 0 : reg[addr], subject to the optional bypass below.
- Zero-cycle latency.

Scoreboard:
- One CNT_W-bit counter per register index 1..NREG-1. Index 0 is never counted: issue, WB and kill events targeting 0 are ignored.
- Per clk edge, for each index i:
  - inc = issue_valid && issue_dst==i.
  - dec = (RegWrite && RegWriteDst==i) + (kill_valid && kill_dst==i); dec ranges 0..2.
  - next = cnt + inc - dec.
- Simultaneous events are all applied in the same cycle. Example: issue and WB to the same index gives an unchanged count.
- Overflow: if cnt + inc - dec > max, the counter saturates at max and err_sticky <= 1.
- Underflow: if the result is < 0, the counter clamps at 0 and err_sticky <= 1.
- err_sticky clears only on reset.

busy_x:
- Derived combinationally from the current (pre-edge) counter.
- A WB in the current cycle does not clear busy until the next cycle; the forwarding unit covers that cycle.

Reset mid-operation:
- Asynchronous reset immediately clears all state regardless of pending events.
- Events in the cycle of reset deassertion are taken normally on the first edge after deassertion.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - If RegWrite=1, RegWriteDst!=0 and rd_addr_x==RegWriteDst, then rd_data_x = MEM_WB_Forward_Data in the same cycle (write-before-read).
  - busy_x is additionally forced 0 when the counter equals 1 and that same WB is in progress.
- Undefined:
  - Reads return the stored value only; the new value is visible the cycle after the write.
  - busy_x is as specified above.

Test Plan:
- Reset, then read addr 5 and addr 0 -> rd_data_a=0, rd_data_b=0, busy_a=busy_b=0, err_sticky=0.
- WB RegWrite=1, Dst=0, data 0xDEADBEEF, then read 0 -> 0. WB Dst=7, data 0x12345678, next cycle read 7 -> 0x12345678.
- Same-cycle WB Dst=3, data 0xA5A5A5A5 with rd_addr_a=3 (reg3 previously 0x11111111):
  - With REGFILE_WRITE_BYPASS_EN -> 0xA5A5A5A5 immediately.
  - Without -> 0x11111111 this cycle, 0xA5A5A5A5 next cycle.
- issue_dst=9 on two consecutive cycles -> busy on addr 9 = 1. One WB Dst=9 -> still busy. Second WB Dst=9 -> busy_a=0 the following cycle.
- Same cycle: issue_dst=4, WB Dst=4, kill_dst=4 with cnt[4]=2 -> cnt[4]=1 (busy stays 1); err_sticky stays 0.
- Four issues to index 2 without WB -> counter saturates at 3, err_sticky=1. Kill to index 6 with cnt[6]=0 -> remains 0, err_sticky=1. Assert reset mid-sequence -> all busy=0, err_sticky=0 immediately.
